// File: rtl/glip_tx_arbiter_pkg.sv
// Shared types and header packing for the GLIP host-bound arbiter.
package glip_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } arb_state_t;

  localparam int HDR_ID_LSB  = 0;
  localparam int HDR_LEN_LSB = 8;

  // Packed into 64 bits; the caller truncates to its word width.
  function automatic logic [63:0] hdr_word(
    input logic [7:0]  id,
    input logic [55:0] len
  );
    logic [63:0] w;
    w = (64'(id) << HDR_ID_LSB) | (64'(len) << HDR_LEN_LSB);
    return w;
  endfunction

endpackage

// File: rtl/glip_tx_arbiter_rr_select.sv
// Combinational round-robin picker: searches upward from last+1, wrapping.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i > int'(last))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
    // Wrap-around pass over channels at or below the last grant.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i <= int'(last))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/glip_tx_arbiter.sv
// Round-robin sharing of one GLIP host-bound FIFO between on-chip requesters.
module glip_tx_arbiter
  import glip_tx_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           req_valid,
  input  logic [CHANNELS*LEN_WIDTH-1:0] req_len,
  output logic [CHANNELS-1:0]           req_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  output logic [WIDTH-1:0]              fifo_out_data,
  output logic                          fifo_out_valid,
  input  logic                          fifo_out_ready,
  output logic                          busy,
  output logic [3:0]                    cur_channel
);

  arb_state_t           state, nxt;
  logic [3:0]           last_grant;
  logic [LEN_WIDTH-1:0] len, cnt, len_sel;
  logic [CHANNELS-1:0]  grant;
  logic [3:0]           gidx;
  logic                 gany, take;
  logic                 ch_valid, fire;
  logic [WIDTH-1:0]     ch_data;

  rr_select #(
    .N  (CHANNELS),
    .IW (4)
  ) u_sel (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // rst_n gate keeps the grant silent while reset is held.
  assign take = (state == IDLE) && enable && gany && rst_n;
  assign fire = (state == DATA) && ch_valid && fifo_out_ready;

  always_comb begin
    len_sel  = '0;
    ch_valid = 1'b0;
    ch_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i])
        len_sel = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      if (cur_channel == 4'(i)) begin
        ch_valid = in_valid[i];
        ch_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    nxt            = state;
    req_ready      = '0;
    in_ready       = '0;
    fifo_out_valid = 1'b0;
    fifo_out_data  = '0;
    unique case (state)
      IDLE: begin
        if (take) begin
          req_ready = grant;
          nxt       = HEADER;
        end
      end
      HEADER: begin
        fifo_out_valid = 1'b1;
        fifo_out_data  = WIDTH'(hdr_word(8'(cur_channel), 56'(len)));
        if (fifo_out_ready)
          nxt = DATA;
      end
      DATA: begin
        fifo_out_valid = ch_valid;
        fifo_out_data  = ch_data;
        for (int i = 0; i < CHANNELS; i++)
          in_ready[i] = (cur_channel == 4'(i)) && fifo_out_ready;
        if (fire && cnt == '0)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 4'(CHANNELS-1);
      cnt         <= '0;
      len         <= '0;
      cur_channel <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        cur_channel <= gidx;
        last_grant  <= gidx;
        len         <= len_sel;
        cnt         <= len_sel;
      end else if (fire && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_glip_tx_arbiter.sv
// Directed self-checking bench for glip_tx_arbiter.
module tb_glip_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_len;
  logic [3:0]  req_ready;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] fifo_out_data;
  logic        fifo_out_valid;
  logic        fifo_out_ready;
  logic        busy;
  logic [3:0]  cur_channel;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  glip_tx_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .req_valid      (req_valid),
    .req_len        (req_len),
    .req_ready      (req_ready),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fifo_out_data  (fifo_out_data),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ready (fifo_out_ready),
    .busy           (busy),
    .cur_channel    (cur_channel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    enable         = 1'b1;
    req_valid      = '0;
    req_len        = '0;
    in_data        = '0;
    in_valid       = 4'hf;
    fifo_out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    enable = 1'b1; req_valid = '0; req_len = '0;
    in_data = '0; in_valid = '0; fifo_out_ready = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", fifo_out_valid, 0);
    chk("rst_data", fifo_out_data, 0);
    chk("rst_cur", cur_channel, 0);
    do_reset();

    // single burst on channel 0, len-1 = 2
    req_valid = 4'b0001;
    req_len[0 +: 8] = 8'd2;
    in_data[0 +: 16] = 16'ha000;
    #1;
    chk("t1_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    chk("t1_hdr", fifo_out_data, 16'h0200);
    chk("t1_hvalid", fifo_out_valid, 1);
    step();
    for (int w = 0; w < 3; w++) begin
      in_data[0 +: 16] = 16'ha000 + 16'(w);
      #1;
      chk("t1_data", fifo_out_data, 16'ha000 + 16'(w));
      chk("t1_inrdy", in_ready, 4'b0001);
      step();
    end
    chk("t1_idle", busy, 0);
    chk("t1_ivalid", fifo_out_valid, 0);
    chk("t1_cur", cur_channel, 0);

    // all channels requesting one-word bursts: rotation 0..3
    do_reset();
    for (int i = 0; i < 4; i++)
      in_data[i*16 +: 16] = 16'hc000 + 16'(i);
    req_valid = 4'hf;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_grant", req_ready, 32'(1) << (k % 4));
      step();
      chk("t2_hdr", fifo_out_data, 32'(k % 4));
      step();
      chk("t2_data", fifo_out_data, 32'h0000c000 + 32'(k % 4));
      chk("t2_cur", cur_channel, 32'(k % 4));
      step();
    end
    req_valid = '0;
    #1;
    chk("t2_idle", busy, 0);

    // ready toggling during a 4-word burst on channel 2
    do_reset();
    fifo_out_ready = 1'b0;
    req_len[16 +: 8] = 8'd3;
    req_valid = 4'b0100;
    in_data[32 +: 16] = 16'hb000;
    #1;
    chk("t3_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("t3_hdr", fifo_out_data, 16'h0302);
    step();
    chk("t3_hdr_hold", fifo_out_data, 16'h0302);
    chk("t3_hv_hold", fifo_out_valid, 1);
    fifo_out_ready = 1'b1;
    #1;
    chk("t3_hdr_inrdy", in_ready, 0);
    step();
    for (int w = 0; w < 4; w++) begin
      in_data[32 +: 16] = 16'hb000 + 16'(w);
      fifo_out_ready = 1'b0;
      #1;
      chk("t3_data_lo", fifo_out_data, 16'hb000 + 16'(w));
      chk("t3_inrdy_lo", in_ready, 0);
      step();
      chk("t3_data_hold", fifo_out_data, 16'hb000 + 16'(w));
      fifo_out_ready = 1'b1;
      #1;
      chk("t3_inrdy_hi", in_ready, 4'b0100);
      step();
    end
    chk("t3_done", busy, 0);

    // requester stalls 5 cycles mid-burst on channel 1
    req_len[8 +: 8] = 8'd1;
    req_valid = 4'b0010;
    in_data[16 +: 16] = 16'hd000;
    #1;
    chk("t4_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    chk("t4_hdr", fifo_out_data, 16'h0101);
    step();
    chk("t4_d0", fifo_out_data, 16'hd000);
    step();
    in_valid[1] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t4_stall_v", fifo_out_valid, 0);
      chk("t4_stall_busy", busy, 1);
      step();
    end
    in_valid[1] = 1'b1;
    in_data[16 +: 16] = 16'hd001;
    #1;
    chk("t4_d1", fifo_out_data, 16'hd001);
    chk("t4_d1v", fifo_out_valid, 1);
    step();
    chk("t4_done", busy, 0);

    // enable drops mid-burst on channel 1 while channel 2 waits
    in_data[16 +: 16] = 16'hd100;
    req_valid = 4'b0010;
    #1;
    chk("t5_grant1", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    enable = 1'b0;
    req_valid = 4'b0100;
    req_len[16 +: 8] = 8'd0;
    in_data[32 +: 16] = 16'he000;
    #1;
    chk("t5_nogrant", req_ready, 0);
    step();
    in_data[16 +: 16] = 16'hd101;
    #1;
    chk("t5_last", fifo_out_data, 16'hd101);
    step();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t5_held", req_ready, 0);
      chk("t5_idle", busy, 0);
      step();
    end
    enable = 1'b1;
    #1;
    chk("t5_grant2", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("t5_hdr", fifo_out_data, 16'h0002);
    step();
    chk("t5_data", fifo_out_data, 16'he000);
    step();
    chk("t5_done", busy, 0);

    // asynchronous reset in DATA, then 0 beats 3 after reset
    req_len[0 +: 8] = 8'd5;
    in_data[0 +: 16] = 16'hf000;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("t6_r_busy", busy, 0);
    chk("t6_r_valid", fifo_out_valid, 0);
    chk("t6_r_data", fifo_out_data, 0);
    chk("t6_r_inrdy", in_ready, 0);
    chk("t6_r_reqrdy", req_ready, 0);
    chk("t6_r_cur", cur_channel, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    chk("t6_cur", cur_channel, 0);
    chk("t6_hdr", fifo_out_data, 16'h0500);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
